// File: rtl/serpent_round_ctrl_if.sv
// Handshake and datapath bundle between the Serpent round controller and its environment:
// block/key sourcing, the shared external S-box datapath, and the result.
interface serpent_round_ctrl_if;
  logic         i_start;
  logic [127:0] i_block;
  logic [5:0]   o_key_idx;
  logic [127:0] i_round_key;
  logic         i_key_valid;
  logic [31:0]  o_sbox_word0;
  logic [31:0]  o_sbox_word1;
  logic [31:0]  o_sbox_word2;
  logic [31:0]  o_sbox_word3;
  logic [2:0]   o_sbox_index;
  logic [127:0] i_sbox_data;
  logic         o_busy;
  logic         o_done;
  logic [127:0] o_data;

  modport master (
    output i_start, i_block, i_round_key, i_key_valid, i_sbox_data,
    input  o_key_idx, o_sbox_word0, o_sbox_word1, o_sbox_word2, o_sbox_word3,
    input  o_sbox_index, o_busy, o_done, o_data
  );

  modport slave (
    input  i_start, i_block, i_round_key, i_key_valid, i_sbox_data,
    output o_key_idx, o_sbox_word0, o_sbox_word1, o_sbox_word2, o_sbox_word3,
    output o_sbox_index, o_busy, o_done, o_data
  );
endinterface

// File: rtl/serpent_round_ctrl.sv
// Iterative Serpent encryption controller: one round per cycle using an external S-box
// datapath, with per-round key requests that may stall on i_key_valid.
module serpent_round_ctrl (
  input  logic i_clk,
  input  logic i_rst_n,
  serpent_round_ctrl_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRound = 2'd1;
  localparam logic [1:0] StFinal = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]   st_q, st_d;
  logic [5:0]   r_q, r_d;
  logic [127:0] state_q, state_d;
  logic [127:0] data_q, data_d;
  logic [127:0] mix;

  function automatic logic [127:0] lin_trans(input logic [127:0] x);
    logic [31:0] x0, x1, x2, x3;
    x0 = x[31:0];
    x1 = x[63:32];
    x2 = x[95:64];
    x3 = x[127:96];
    x0 = {x0[18:0], x0[31:19]};
    x2 = {x2[28:0], x2[31:29]};
    x1 = x1 ^ x0 ^ x2;
    x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = {x1[30:0], x1[31]};
    x3 = {x3[24:0], x3[31:25]};
    x0 = x0 ^ x1 ^ x3;
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = {x0[26:0], x0[31:27]};
    x2 = {x2[9:0], x2[31:10]};
    return {x3, x2, x1, x0};
  endfunction

  assign mix = state_q ^ bus.i_round_key;

  always_comb begin
    st_d    = st_q;
    r_d     = r_q;
    state_d = state_q;
    data_d  = data_q;
    unique case (st_q)
      StIdle: begin
        if (bus.i_start) begin
          state_d = bus.i_block;
          r_d     = 6'd0;
          st_d    = StRound;
        end
      end
      StRound: begin
        if (bus.i_key_valid) begin
          // Last round skips the linear transform; the final key is mixed in FINAL.
          if (r_q == 6'd31) begin
            state_d = bus.i_sbox_data;
            st_d    = StFinal;
          end else begin
            state_d = lin_trans(bus.i_sbox_data);
            r_d     = r_q + 6'd1;
          end
        end
      end
      StFinal: begin
        if (bus.i_key_valid) begin
          data_d = mix;
          st_d   = StDone;
        end
      end
      StDone: st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q    <= StIdle;
      r_q     <= 6'd0;
      state_q <= '0;
      data_q  <= '0;
    end else begin
      st_q    <= st_d;
      r_q     <= r_d;
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    bus.o_key_idx    = 6'd0;
    bus.o_sbox_word0 = '0;
    bus.o_sbox_word1 = '0;
    bus.o_sbox_word2 = '0;
    bus.o_sbox_word3 = '0;
    bus.o_sbox_index = 3'd0;
    if (st_q == StRound) begin
      bus.o_key_idx    = r_q;
      bus.o_sbox_word0 = mix[31:0];
      bus.o_sbox_word1 = mix[63:32];
      bus.o_sbox_word2 = mix[95:64];
      bus.o_sbox_word3 = mix[127:96];
      bus.o_sbox_index = r_q[2:0];
    end else if (st_q == StFinal) begin
      bus.o_key_idx = 6'd32;
    end
  end

  assign bus.o_busy = (st_q != StIdle);
  assign bus.o_done = (st_q == StDone);
  assign bus.o_data = data_q;

endmodule
